// File: rtl/dm_pkg.sv
// Shared types and constants for the dual-requester data-memory controller.
package dm_pkg;

  localparam int DM_AW    = 6;
  localparam int DM_LANES = 4;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;
  localparam logic [1:0] W_ILL  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} dm_state_t;

  function automatic logic [DM_LANES-1:0] lane_mask(input logic [1:0] w);
    case (w)
      W_BYTE:  return 4'b0001;
      W_HALF:  return 4'b0011;
      W_WORD:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Zero/sign fill of a little-endian load from the lane read bytes.
  function automatic logic [31:0] ld_fmt(input logic [DM_LANES-1:0][7:0] d,
                                         input logic [1:0] w, input logic sx);
    case (w)
      W_BYTE:  return {{24{sx & d[0][7]}}, d[0]};
      W_HALF:  return {{16{sx & d[1][7]}}, d[1], d[0]};
      W_WORD:  return d;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/dm_rr_arb.sv
// Two-way round-robin arbiter; grant[0] = A, grant[1] = B.
module dm_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic r_last_b;

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = r_last_b ? 2'b01 : 2'b10;
  end

  // Reset favours A on the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_last_b <= 1'b1;
    else if (advance && |grant)   r_last_b <= grant[1];
  end

endmodule

// File: rtl/dm_ctrl.sv
// Data-memory controller: arbitrates A/B, splits accesses over four byte banks.
module dm_ctrl
  import dm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [1:0]  a_width,
  input  logic        a_sext,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_done,
  output logic [31:0] a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [1:0]  b_width,
  input  logic        b_sext,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_done,
  output logic [31:0] b_rdata,
  output logic        b_err,
  output logic [3:0]  ram_we,
  output logic [5:0]  ram_addr0,
  output logic [5:0]  ram_addr1,
  output logic [5:0]  ram_addr2,
  output logic [5:0]  ram_addr3,
  output logic [7:0]  ram_wdata0,
  output logic [7:0]  ram_wdata1,
  output logic [7:0]  ram_wdata2,
  output logic [7:0]  ram_wdata3,
  input  logic [7:0]  ram_rdata0,
  input  logic [7:0]  ram_rdata1,
  input  logic [7:0]  ram_rdata2,
  input  logic [7:0]  ram_rdata3
);

  dm_state_t r_state;
  logic      r_own_b, r_we, r_sext, r_err;
  logic [1:0]  r_width;
  logic [31:0] r_load;
  logic        r_a_gnt, r_a_done, r_a_err, r_b_gnt, r_b_done, r_b_err;
  logic [31:0] r_a_rdata, r_b_rdata;
  logic [DM_LANES-1:0]            r_ram_we;
  logic [DM_LANES-1:0][DM_AW-1:0] r_ram_addr;
  logic [DM_LANES-1:0][7:0]       r_ram_wdata;

  logic [1:0]  w_req, w_grant;
  logic        w_adv, w_sel_b, w_we, w_sext, w_bad;
  logic [1:0]  w_width;
  logic [31:0] w_addr, w_wdata;
  logic [DM_LANES-1:0]      w_mask;
  logic [DM_LANES-1:0][7:0] w_rd;

  // The requester just completing still holds req during its done cycle.
  assign w_req   = {b_req & ~r_b_done, a_req & ~r_a_done};
  assign w_adv   = (r_state == S_IDLE) && (|w_req);
  assign w_sel_b = w_grant[1];
  assign w_we    = w_sel_b ? b_we    : a_we;
  assign w_width = w_sel_b ? b_width : a_width;
  assign w_sext  = w_sel_b ? b_sext  : a_sext;
  assign w_addr  = w_sel_b ? b_addr  : a_addr;
  assign w_wdata = w_sel_b ? b_wdata : a_wdata;
  assign w_bad   = (w_width == W_ILL) || (|w_addr[31:DM_AW]);
  assign w_mask  = lane_mask(w_width);
  assign w_rd    = {ram_rdata3, ram_rdata2, ram_rdata1, ram_rdata0};

  dm_rr_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (w_req),
    .advance (w_adv),
    .grant   (w_grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_own_b <= 1'b0;  r_we <= 1'b0;  r_sext <= 1'b0;  r_err <= 1'b0;
      r_width <= '0;    r_load <= '0;
      r_a_gnt <= 1'b0;  r_a_done <= 1'b0;  r_a_err <= 1'b0;  r_a_rdata <= '0;
      r_b_gnt <= 1'b0;  r_b_done <= 1'b0;  r_b_err <= 1'b0;  r_b_rdata <= '0;
      r_ram_we <= '0;   r_ram_addr <= '0;  r_ram_wdata <= '0;
    end else begin
      r_a_gnt <= 1'b0;  r_a_done <= 1'b0;  r_a_err <= 1'b0;  r_a_rdata <= '0;
      r_b_gnt <= 1'b0;  r_b_done <= 1'b0;  r_b_err <= 1'b0;  r_b_rdata <= '0;
      r_ram_we <= '0;   r_ram_addr <= '0;  r_ram_wdata <= '0;
      case (r_state)
        S_IDLE: if (w_adv) begin
          r_own_b <= w_sel_b;
          r_we    <= w_we;
          r_width <= w_width;
          r_sext  <= w_sext;
          r_err   <= w_bad;
          r_load  <= '0;
          r_a_gnt <= ~w_sel_b;
          r_b_gnt <= w_sel_b;
          // RAM lanes are driven from the grant edge so they are live in ACCESS.
          if (!w_bad) begin
            for (int i = 0; i < DM_LANES; i++) begin
              if (w_mask[i]) begin
                r_ram_addr[i] <= w_addr[DM_AW-1:0] + DM_AW'(i);
                if (w_we) begin
                  r_ram_we[i]    <= 1'b1;
                  r_ram_wdata[i] <= w_wdata[8*i +: 8];
                end
              end
            end
          end
          r_state <= S_ACCESS;
        end
        S_ACCESS: r_state <= (r_we || r_err) ? S_RESP : S_WAIT;
        S_WAIT: begin
          r_load  <= ld_fmt(w_rd, r_width, r_sext);
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (r_own_b) begin
            r_b_done <= 1'b1;  r_b_err <= r_err;  r_b_rdata <= r_load;
          end else begin
            r_a_done <= 1'b1;  r_a_err <= r_err;  r_a_rdata <= r_load;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign a_gnt   = r_a_gnt;
  assign a_done  = r_a_done;
  assign a_err   = r_a_err;
  assign a_rdata = r_a_rdata;
  assign b_gnt   = r_b_gnt;
  assign b_done  = r_b_done;
  assign b_err   = r_b_err;
  assign b_rdata = r_b_rdata;
  assign ram_we  = r_ram_we;
  assign ram_addr0  = r_ram_addr[0];
  assign ram_addr1  = r_ram_addr[1];
  assign ram_addr2  = r_ram_addr[2];
  assign ram_addr3  = r_ram_addr[3];
  assign ram_wdata0 = r_ram_wdata[0];
  assign ram_wdata1 = r_ram_wdata[1];
  assign ram_wdata2 = r_ram_wdata[2];
  assign ram_wdata3 = r_ram_wdata[3];

endmodule

// File: tb/tb_dm_ctrl.sv
// Self-checking bench for dm_ctrl: banked RAM stand-in plus a byte-level reference memory.
module tb_dm_ctrl;

  logic        clk, rst;
  logic        a_req, a_we, a_sext, b_req, b_we, b_sext;
  logic [1:0]  a_width, b_width;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_done, a_err, b_gnt, b_done, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic [3:0]  ram_we;
  logic [5:0]  ram_addr0, ram_addr1, ram_addr2, ram_addr3;
  logic [7:0]  ram_wdata0, ram_wdata1, ram_wdata2, ram_wdata3;
  logic [7:0]  ram_rdata0, ram_rdata1, ram_rdata2, ram_rdata3;

  int vec = 0, errs = 0;

  dm_ctrl dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_width(a_width), .a_sext(a_sext), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_width(b_width), .b_sext(b_sext), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata), .b_err(b_err),
    .ram_we(ram_we),
    .ram_addr0(ram_addr0), .ram_addr1(ram_addr1), .ram_addr2(ram_addr2), .ram_addr3(ram_addr3),
    .ram_wdata0(ram_wdata0), .ram_wdata1(ram_wdata1), .ram_wdata2(ram_wdata2), .ram_wdata3(ram_wdata3),
    .ram_rdata0(ram_rdata0), .ram_rdata1(ram_rdata1), .ram_rdata2(ram_rdata2), .ram_rdata3(ram_rdata3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM banks: read data appears the cycle after the address.
  logic [7:0] bank [4][64];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) for (int j = 0; j < 64; j++) bank[i][j] <= 8'h00;
    end else begin
      if (ram_we[0]) bank[0][ram_addr0] <= ram_wdata0;
      if (ram_we[1]) bank[1][ram_addr1] <= ram_wdata1;
      if (ram_we[2]) bank[2][ram_addr2] <= ram_wdata2;
      if (ram_we[3]) bank[3][ram_addr3] <= ram_wdata3;
      ram_rdata0 <= bank[0][ram_addr0];
      ram_rdata1 <= bank[1][ram_addr1];
      ram_rdata2 <= bank[2][ram_addr2];
      ram_rdata3 <= bank[3][ram_addr3];
    end
  end

  // Write-strobe monitor: running cycle count plus snapshot of the last strobe.
  int         we_cnt = 0;
  logic [3:0] s_we;
  logic [5:0] s_a [4];
  logic [7:0] s_d [4];
  always @(negedge clk) if (|ram_we) begin
    we_cnt <= we_cnt + 1;
    s_we   <= ram_we;
    s_a[0] <= ram_addr0;  s_a[1] <= ram_addr1;  s_a[2] <= ram_addr2;  s_a[3] <= ram_addr3;
    s_d[0] <= ram_wdata0; s_d[1] <= ram_wdata1; s_d[2] <= ram_wdata2; s_d[3] <= ram_wdata3;
  end

  // Reference memory: ref_mem[lane][row], lane i of an access touches row (addr+i) mod 64.
  logic [7:0] ref_mem [4][64];

  function automatic int nl(input logic [1:0] w);
    case (w)
      2'b00: return 1;
      2'b01: return 2;
      2'b10: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit ref_err(input logic [1:0] w, input logic [31:0] ad);
    return (w == 2'b11) || (ad[31:6] != 26'd0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] w, input bit sx, input logic [31:0] ad);
    logic [31:0] v;
    int n;
    v = 32'h0;
    n = nl(w);
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[i][(int'(ad[5:0]) + i) % 64];
    if (sx && n > 0 && n < 4 && v[8*n-1]) for (int k = 8*n; k < 32; k++) v[k] = 1'b1;
    return v;
  endfunction

  function automatic void ref_store(input logic [1:0] w, input logic [31:0] ad, input logic [31:0] wd);
    for (int i = 0; i < nl(w); i++) ref_mem[i][(int'(ad[5:0]) + i) % 64] = wd[8*i +: 8];
  endfunction

  // Drives one access, scrambles the inputs after the grant, returns what was observed.
  task automatic run_access(input bit who, input bit we, input logic [1:0] wd, input bit sx,
                            input logic [31:0] ad, input logic [31:0] wdat,
                            output logic [31:0] rd, output bit er, output int lat,
                            output int oth, output int pulses);
    bit got;
    int base;
    rd = 32'h0; er = 1'b0; lat = -1; oth = 0; got = 1'b0;
    base = we_cnt;
    if (!who) begin a_we = we; a_width = wd; a_sext = sx; a_addr = ad; a_wdata = wdat; a_req = 1'b1; end
    else      begin b_we = we; b_width = wd; b_sext = sx; b_addr = ad; b_wdata = wdat; b_req = 1'b1; end
    for (int n = 0; n < 40 && !got; n++) begin
      @(posedge clk); #1;
      got = who ? b_gnt : a_gnt;
    end
    if (got) begin
      if (!who) begin a_we = $urandom; a_width = 2'($urandom); a_sext = $urandom; a_addr = $urandom; a_wdata = $urandom; end
      else      begin b_we = $urandom; b_width = 2'($urandom); b_sext = $urandom; b_addr = $urandom; b_wdata = $urandom; end
      got = 1'b0;
      for (int n = 1; n <= 20 && !got; n++) begin
        @(posedge clk); #1;
        if (who ? (a_gnt | a_done | a_err | (|a_rdata)) : (b_gnt | b_done | b_err | (|b_rdata))) oth++;
        if (who ? b_done : a_done) begin
          got = 1'b1; lat = n;
          rd = who ? b_rdata : a_rdata;
          er = who ? b_err : a_err;
        end
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    pulses = we_cnt - base;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if ({a_gnt, a_done, a_err, a_rdata, b_gnt, b_done, b_err, b_rdata} !== '0) begin
      errs++; $display("FAIL reset_req_outs: got %h want 0", {a_gnt, a_done, a_err, a_rdata, b_gnt, b_done, b_err, b_rdata});
    end
    vec++;
    if ({ram_we, ram_addr0, ram_addr1, ram_addr2, ram_addr3, ram_wdata0, ram_wdata1, ram_wdata2, ram_wdata3} !== '0) begin
      errs++; $display("FAIL reset_ram_outs: got %h want 0",
        {ram_we, ram_addr0, ram_addr1, ram_addr2, ram_addr3, ram_wdata0, ram_wdata1, ram_wdata2, ram_wdata3});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [3:0] ord;
    int ng, nd, bad, last_g;
    ord = 4'h0; ng = 0; nd = 0; bad = 0; last_g = 2;
    a_we = 1'b1; a_width = 2'b10; a_sext = 1'b0; a_addr = 32'h10; a_wdata = 32'h11223344;
    b_we = 1'b1; b_width = 2'b01; b_sext = 1'b0; b_addr = 32'h20; b_wdata = 32'h0000A5C3;
    a_req = 1'b1; b_req = 1'b1;
    for (int c = 0; c < 80 && nd < 4; c++) begin
      @(posedge clk); #1;
      if (a_gnt && b_gnt) bad++;
      if (a_gnt || b_gnt) begin
        if (ng < 4) ord[ng] = b_gnt;
        ng++;
        last_g = b_gnt ? 1 : 0;
      end
      if (a_done) begin if (last_g != 0 || b_done) bad++; nd++; end
      if (b_done) begin if (last_g != 1) bad++; nd++; end
    end
    a_req = 1'b0; b_req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    ref_store(2'b10, 32'h10, 32'h11223344);
    ref_store(2'b01, 32'h20, 32'h0000A5C3);
    vec++;
    if (nd != 4) begin errs++; $display("FAIL rr_done_count: got %0d want 4", nd); end
    vec++;
    if (ord !== 4'b1010) begin errs++; $display("FAIL rr_order: got %b want 1010 (bit0 first, 0=A)", ord); end
    vec++;
    if (bad != 0) begin errs++; $display("FAIL rr_owner_routing: got %0d bad events want 0", bad); end
  endtask

  task automatic test_store_word();
    logic [31:0] rd; bit er; int lat, oth, p;
    run_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h04, 32'hDEADBEEF, rd, er, lat, oth, p);
    ref_store(2'b10, 32'h04, 32'hDEADBEEF);
    vec++;
    if (lat != 2) begin errs++; $display("FAIL sw_latency: got %0d want 2", lat); end
    vec++;
    if (p != 1 || s_we !== 4'hF) begin errs++; $display("FAIL sw_strobe: got %0d cycles we=%b want 1 cycle we=1111", p, s_we); end
    vec++;
    if ({s_a[3], s_a[2], s_a[1], s_a[0]} !== {6'h07, 6'h06, 6'h05, 6'h04}) begin
      errs++; $display("FAIL sw_addr: got %h %h %h %h want 04 05 06 07", s_a[0], s_a[1], s_a[2], s_a[3]);
    end
    vec++;
    if ({s_d[3], s_d[2], s_d[1], s_d[0]} !== 32'hDEADBEEF) begin
      errs++; $display("FAIL sw_data: got %h want deadbeef", {s_d[3], s_d[2], s_d[1], s_d[0]});
    end
    vec++;
    if (rd !== 32'h0 || er !== 1'b0 || oth != 0) begin
      errs++; $display("FAIL sw_resp: got rdata=%h err=%b oth=%0d want 0 0 0", rd, er, oth);
    end
  endtask

  task automatic test_load_half();
    logic [31:0] rd; bit er; int lat, oth, p;
    run_access(1'b1, 1'b1, 2'b01, 1'b0, 32'h08, 32'h1234F080, rd, er, lat, oth, p);
    ref_store(2'b01, 32'h08, 32'h1234F080);
    run_access(1'b0, 1'b0, 2'b01, 1'b1, 32'h08, 32'h0, rd, er, lat, oth, p);
    vec++;
    if (rd !== 32'hFFFFF080) begin errs++; $display("FAIL lh_sext: got %h want fffff080", rd); end
    vec++;
    if (lat != 3) begin errs++; $display("FAIL lh_latency: got %0d want 3", lat); end
    run_access(1'b0, 1'b0, 2'b01, 1'b0, 32'h08, 32'h0, rd, er, lat, oth, p);
    vec++;
    if (rd !== 32'h0000F080) begin errs++; $display("FAIL lh_zext: got %h want 0000f080", rd); end
    vec++;
    if (p != 0 || er !== 1'b0) begin errs++; $display("FAIL lh_no_write: got %0d strobes err=%b want 0 0", p, er); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd, wd; bit er; int lat, oth, p;
    wd = $urandom;
    run_access(1'b1, 1'b1, 2'b10, 1'b0, 32'h3F, wd, rd, er, lat, oth, p);
    ref_store(2'b10, 32'h3F, wd);
    vec++;
    if ({s_a[3], s_a[2], s_a[1], s_a[0]} !== {6'h02, 6'h01, 6'h00, 6'h3F} || s_we !== 4'hF || p != 1) begin
      errs++; $display("FAIL wrap_addr: got %h %h %h %h we=%b n=%0d want 3f 00 01 02 1111 1",
                       s_a[0], s_a[1], s_a[2], s_a[3], s_we, p);
    end
    run_access(1'b0, 1'b0, 2'b10, 1'b0, 32'h3F, 32'h0, rd, er, lat, oth, p);
    vec++;
    if (rd !== wd) begin errs++; $display("FAIL wrap_readback: got %h want %h", rd, wd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; bit er; int lat, oth, p;
    run_access(1'b0, 1'b1, 2'b11, 1'b0, 32'h04, 32'hFFFFFFFF, rd, er, lat, oth, p);
    vec++;
    if (er !== 1'b1 || rd !== 32'h0 || p != 0 || lat != 2) begin
      errs++; $display("FAIL err_width: got err=%b rdata=%h strobes=%0d lat=%0d want 1 0 0 2", er, rd, p, lat);
    end
    run_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hFFFFFFFF, rd, er, lat, oth, p);
    vec++;
    if (er !== 1'b1 || rd !== 32'h0 || p != 0 || lat != 2) begin
      errs++; $display("FAIL err_addr: got err=%b rdata=%h strobes=%0d lat=%0d want 1 0 0 2", er, rd, p, lat);
    end
  endtask

  task automatic test_withdraw();
    logic [31:0] rd, exp; bit er; int lat, oth, p, bg;
    bg = 0;
    exp = ref_load(2'b10, 1'b0, 32'h20);
    fork
      run_access(1'b0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat, oth, p);
      begin
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin @(posedge clk); #1; seen = a_gnt; end
        b_we = 1'b1; b_width = 2'b10; b_addr = 32'h30; b_wdata = 32'hCAFEF00D; b_sext = 1'b0;
        b_req = 1'b1;
        @(posedge clk); #1;
        b_req = 1'b0;
        for (int n = 0; n < 12; n++) begin @(posedge clk); #1; if (b_gnt) bg++; end
      end
    join
    vec++;
    if (bg != 0 || oth != 0) begin errs++; $display("FAIL withdraw_gnt: got b_gnt=%0d oth=%0d want 0 0", bg, oth); end
    vec++;
    if (rd !== exp) begin errs++; $display("FAIL withdraw_load: got %h want %h", rd, exp); end
    exp = ref_load(2'b10, 1'b0, 32'h30);
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd, er, lat, oth, p);
    vec++;
    if (rd !== exp) begin errs++; $display("FAIL withdraw_mem: got %h want %h", rd, exp); end
  endtask

  task automatic test_random();
    logic [31:0] rd, ad, wd, erd; bit er, eer, who, we, sx; logic [1:0] w; int lat, oth, p, elat, ep;
    for (int t = 0; t < 40; t++) begin
      who = $urandom; we = $urandom; sx = $urandom; w = 2'($urandom);
      ad = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63));
      wd = $urandom;
      eer  = ref_err(w, ad);
      erd  = (eer || we) ? 32'h0 : ref_load(w, sx, ad);
      elat = (!eer && !we) ? 3 : 2;
      ep   = (!eer && we) ? 1 : 0;
      run_access(who, we, w, sx, ad, wd, rd, er, lat, oth, p);
      if (!eer && we) ref_store(w, ad, wd);
      vec++;
      if (rd !== erd || er !== eer || lat != elat || p != ep || oth != 0) begin
        errs++;
        $display("FAIL rand_%0d: got rdata=%h err=%b lat=%0d strobes=%0d oth=%0d want %h %b %0d %0d 0 (who=%b we=%b w=%b sx=%b addr=%h)",
                 t, rd, er, lat, p, oth, erd, eer, elat, ep, who, we, w, sx, ad);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; bit er, seen; int lat, oth, p, nd, base;
    seen = 1'b0;
    a_we = 1'b0; a_width = 2'b10; a_sext = 1'b0; a_addr = 32'h04; a_wdata = 32'h0;
    a_req = 1'b1;
    for (int n = 0; n < 40 && !seen; n++) begin @(posedge clk); #1; seen = a_gnt; end
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    vec++;
    if ({a_gnt, a_done, a_err, a_rdata, ram_we} !== '0) begin
      errs++; $display("FAIL rst_async: got %h want 0", {a_gnt, a_done, a_err, a_rdata, ram_we});
    end
    @(posedge clk); #1;
    a_req = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 64; j++) ref_mem[i][j] = 8'h00;
    nd = 0; base = we_cnt;
    for (int n = 0; n < 10; n++) begin @(posedge clk); #1; if (a_done || b_done) nd++; end
    vec++;
    if (nd != 0 || we_cnt != base) begin
      errs++; $display("FAIL rst_abort: got done=%0d strobes=%0d want 0 0", nd, we_cnt - base);
    end
    run_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h05, 32'h000000C7, rd, er, lat, oth, p);
    ref_store(2'b00, 32'h05, 32'h000000C7);
    run_access(1'b0, 1'b0, 2'b00, 1'b1, 32'h05, 32'h0, rd, er, lat, oth, p);
    vec++;
    if (rd !== ref_load(2'b00, 1'b1, 32'h05) || lat != 3 || er !== 1'b0) begin
      errs++; $display("FAIL rst_recover: got rdata=%h lat=%0d err=%b want %h 3 0", rd, lat, er, ref_load(2'b00, 1'b1, 32'h05));
    end
  endtask

  initial begin
    rst = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_width = 2'b00; a_sext = 1'b0; a_addr = 32'h0; a_wdata = 32'h0;
    b_req = 1'b0; b_we = 1'b0; b_width = 2'b00; b_sext = 1'b0; b_addr = 32'h0; b_wdata = 32'h0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 64; j++) ref_mem[i][j] = 8'h00;
    test_reset();
    test_back_to_back();
    test_store_word();
    test_load_half();
    test_wrap();
    test_errors();
    test_withdraw();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/dm_ctrl.md
DM_CTRL -- requirements
Module: dm_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 Port list, one port per line (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- a_req  in  1  requester A (CPU load/store) access request; held until a_done
- a_we  in  1  A: 1 = store, 0 = load
- a_width  in  2  A: 00 byte, 01 half, 10 word, 11 illegal
- a_sext  in  1  A: sign-extend load result
- a_addr  in  32  A: byte address
- a_wdata  in  32  A: store data, little-endian
- a_gnt  out  1  A: one-cycle pulse when A's request is accepted
- a_done  out  1  A: one-cycle pulse when the access completes
- a_rdata  out  32  A: load result, valid while a_done=1
- a_err  out  1  A: qualifies a_done; access rejected
- b_req, b_we, b_width, b_sext, b_addr, b_wdata, b_gnt, b_done, b_rdata, b_err  same widths and meanings  requester B (debug loader)
- ram_we  out  4  per-lane write strobe, lane i = RAM bank i
- ram_addr0..3  out  6 each  lane addresses
- ram_wdata0..3  out  8 each  lane write data
- ram_rdata0..3  in  8 each  lane read data, valid one cycle after the address cycle (synchronous RAM)

Function
REQ-003 FSM states SHALL be IDLE, ACCESS, WAIT and RESP.
REQ-004 IDLE, with any req high: arbitrate, latch the winner's we/width/sext/addr/wdata, pulse that winner's gnt, go to ACCESS the next cycle.
REQ-005 Arbitration SHALL be 2-way round-robin:
- sole requester wins
- if both request, the one not granted last wins
- the last-granted pointer updates on every grant.
REQ-006 ACCESS, store: drive lane addresses and data, assert ram_we for the active lanes for exactly one cycle, then go to RESP.
REQ-007 ACCESS, load: drive lane addresses with ram_we=0, then go to WAIT; WAIT captures ram_rdata0..3, then go to RESP.
REQ-008 Active lanes:
- byte: lane 0
- half: lanes 0-1
- word: lanes 0-3
- inactive lanes: ram_we=0, ram_addr=0, ram_wdata=0.
REQ-009 Lane i address SHALL be (addr[5:0]+i) mod 64; wrap is legal (addr 63, word → lanes 63, 0, 1, 2).
REQ-010 Store lane i data SHALL be wdata[8i+7:8i].
REQ-011 Load result:
- byte = {24 fill, lane0}; half = {16 fill, lane1, lane0}; word = {lane3..lane0}
- fill = MSB of the loaded value if sext=1, else zeros.
REQ-012 RESP SHALL pulse the owner's done for one cycle with rdata (0 for stores), then return to IDLE.
REQ-013 Latency from gnt to done: store 2 cycles, load 3 cycles. A new grant is possible in the cycle after done.
REQ-014 Error accesses:
- width=11 or addr[31:6]≠0 → ACCESS skips RAM (ram_we=0), goes directly to RESP
- RESP asserts done with err=1 and rdata=0.
REQ-015 Non-owner outputs (gnt, done, err, rdata) SHALL stay 0 throughout an access; requests arriving mid-access wait until IDLE.
REQ-016 Requester inputs SHALL be sampled only at grant; later changes do not affect the access in flight.
REQ-017 Deassertion of a requester's req before its grant SHALL withdraw the request without side effects.

Reset
REQ-018 rst SHALL force, asynchronously:
- state = IDLE
- last-granted pointer = B, so A wins the first contention
- all outputs = 0.
REQ-019 Reset mid-access SHALL abort the access: no done pulse follows, and no ram_we is asserted after rst deasserts until a new grant.

Structure
REQ-020 Shared package dm_pkg SHALL hold:
- width encodings (W_BYTE, W_HALF, W_WORD)
- FSM state type
- DM_AW = 6
- lane count = 4.
REQ-021 Round-robin arbitration SHALL live in sub-module dm_rr_arb (inputs req[1:0], advance; output grant[1:0]); everything else stays in dm_ctrl.

Verification
REQ-022 A store word, addr 0x04, wdata 0xDEADBEEF → one-cycle ram_we=1111 with lanes 04..07 = EF, BE, AD, DE; a_done 2 cycles after a_gnt.
REQ-023 A load half, sext=1, from lanes holding 0x80, 0xF0 → a_rdata = 0xFFFFF080, 3 cycles after a_gnt; same with sext=0 → 0x0000F080.
REQ-024 A and B request in the same cycle, both holding req → grant order A, B, A, B; each done reaches only its owner.
REQ-025 B store word at addr 0x3F → lane addresses 3F, 00, 01, 02; ram_we=1111 for one cycle.
REQ-026 A access with width=11, then A access with addr 0x100 → a_done with a_err=1, no ram_we pulse in either case.
REQ-027 rst asserted in WAIT of a load → no a_done afterwards; the next request is granted normally from IDLE.
